// File: rtl/alu_issue.sv
// Execute-stage issue register feeding the combinational ALU: decode to Operation, forward operands, insert load-use bubbles.
// Latency: one cycle from an ID transfer to registered ex_* outputs.
// Backpressure: id_ready drops on ex_stall or a load-use hazard; flush overrides both and discards the ID instruction.
module alu_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [2:0]               id_class,
  input  logic [2:0]               id_funct3,
  input  logic                     id_funct7b5,
  input  logic                     id_alusrc,
  input  logic                     id_mem_read,
  input  logic                     id_reg_write,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     mem_fwd_en,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     wb_fwd_en,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     ex_stall,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic                     ex_mem_read,
  output logic                     ex_reg_write,
  output logic                     ex_illegal,
  output logic [OPCODE_LENGTH-1:0] ex_operation,
  output logic [DATA_WIDTH-1:0]    ex_srca,
  output logic [DATA_WIDTH-1:0]    ex_srcb,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR-1:0]      ex_rd
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] OP_PASSA = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] OP_NE    = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] OP_GE    = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] OP_PASSB = 4'b1011;
  localparam logic [OPCODE_LENGTH-1:0] OP_LT    = 4'b1100;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = 4'b1110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = 4'b1111;

  localparam logic [2:0] CL_LDST  = 3'b000;
  localparam logic [2:0] CL_BR    = 3'b001;
  localparam logic [2:0] CL_R     = 3'b010;
  localparam logic [2:0] CL_I     = 3'b011;
  localparam logic [2:0] CL_LUI   = 3'b100;
  localparam logic [2:0] CL_JAL   = 3'b101;
  localparam logic [2:0] CL_AUIPC = 3'b110;

  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_valid;
  logic                     r_mem_read;
  logic                     r_reg_write;
  logic                     r_illegal;
  logic [OPCODE_LENGTH-1:0] r_operation;
  logic [DATA_WIDTH-1:0]    r_srca;
  logic [DATA_WIDTH-1:0]    r_srcb;
  logic [DATA_WIDTH-1:0]    r_store_data;
  logic [REG_ADDR-1:0]      r_rd;

  logic [OPCODE_LENGTH-1:0] w_op;
  logic                     w_illegal;
  logic [DATA_WIDTH-1:0]    w_fwd_rs1;
  logic [DATA_WIDTH-1:0]    w_fwd_rs2;
  logic [DATA_WIDTH-1:0]    w_srca;
  logic [DATA_WIDTH-1:0]    w_srcb;
  logic                     w_hazard;
  logic                     w_take_bubble;
  logic                     w_ex_fwd_ok;

  // Load-use hazard: the instruction in EX is a load whose result ID needs now.
  assign w_hazard = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == r_rd)) | (id_uses_rs2 & (id_rs2 == r_rd)));

  assign id_ready      = flush | (~ex_stall & ~w_hazard);
  assign w_take_bubble = (r_state == ST_RUN) & w_hazard & ~ex_stall & ~flush;
  // A load in EX has no result on alu_result yet, so it is never an EX forward source.
  assign w_ex_fwd_ok   = r_valid & r_reg_write & ~r_mem_read;

  // Translate instruction class / funct3 / funct7[5] into the ALU operation code.
  always_comb begin
    w_op      = OP_AND;
    w_illegal = 1'b0;
    case (id_class)
      CL_LDST, CL_AUIPC: w_op = OP_ADD;
      CL_LUI:            w_op = OP_PASSB;
      CL_JAL:            w_op = OP_PASSA;
      CL_BR: begin
        case (id_funct3)
          3'b000:  w_op = OP_EQ;
          3'b001:  w_op = OP_NE;
          3'b100:  w_op = OP_LT;
          3'b101:  w_op = OP_GE;
          default: w_illegal = 1'b1;
        endcase
      end
      CL_R, CL_I: begin
        case (id_funct3)
          3'b000:  w_op = ((id_class == CL_R) && id_funct7b5) ? OP_SUB : OP_ADD;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_LT;
          3'b100:  w_op = OP_XOR;
          3'b101:  w_op = id_funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  w_op = OP_OR;
          3'b111:  w_op = OP_AND;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Operand forwarding, youngest producer first; x0 is never forwarded.
  always_comb begin
    w_fwd_rs1 = id_rs1_data;
    w_fwd_rs2 = id_rs2_data;
    if (id_rs1 != '0) begin
      if (w_ex_fwd_ok && (r_rd == id_rs1))       w_fwd_rs1 = alu_result;
      else if (mem_fwd_en && (mem_rd == id_rs1)) w_fwd_rs1 = mem_data;
      else if (wb_fwd_en && (wb_rd == id_rs1))   w_fwd_rs1 = wb_data;
    end
    if (id_rs2 != '0) begin
      if (w_ex_fwd_ok && (r_rd == id_rs2))       w_fwd_rs2 = alu_result;
      else if (mem_fwd_en && (mem_rd == id_rs2)) w_fwd_rs2 = mem_data;
      else if (wb_fwd_en && (wb_rd == id_rs2))   w_fwd_rs2 = wb_data;
    end
  end

  // Operand selection: PC-relative classes take the PC (JAL/JALR link = pc+4, wrapping).
  always_comb begin
    w_srca = w_fwd_rs1;
    if (id_class == CL_AUIPC)    w_srca = id_pc;
    else if (id_class == CL_JAL) w_srca = id_pc + DATA_WIDTH'(4);
    w_srcb = id_alusrc ? id_imm : w_fwd_rs2;
  end

  // Next state: one bubble cycle after a load-use hazard, flush always returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_take_bubble) w_state_nxt = ST_BUBBLE;
      ST_BUBBLE: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
    if (flush) w_state_nxt = ST_RUN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // EX issue register: reset > flush > stall > bubble > transfer > idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_illegal    <= 1'b0;
      r_operation  <= '0;
      r_srca       <= '0;
      r_srcb       <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (ex_stall) begin
      r_valid <= r_valid;
    end else if (w_take_bubble || !id_valid) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_mem_read   <= id_mem_read;
      r_reg_write  <= id_reg_write;
      r_illegal    <= w_illegal;
      r_operation  <= w_op;
      r_srca       <= w_srca;
      r_srcb       <= w_srcb;
      r_store_data <= w_fwd_rs2;
      r_rd         <= id_rd;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_mem_read   = r_mem_read;
  assign ex_reg_write  = r_reg_write;
  assign ex_illegal    = r_illegal;
  assign ex_operation  = r_operation;
  assign ex_srca       = r_srca;
  assign ex_srcb       = r_srcb;
  assign ex_store_data = r_store_data;
  assign ex_rd         = r_rd;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, forwarding priority, load-use bubble, stall/flush, special classes.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [2:0]  id_class, id_funct3;
  logic        id_funct7b5, id_alusrc, id_mem_read, id_reg_write, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [31:0] alu_result;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        ex_stall, flush;
  logic        ex_valid, ex_mem_read, ex_reg_write, ex_illegal;
  logic [3:0]  ex_operation;
  logic [31:0] ex_srca, ex_srcb, ex_store_data;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_class(id_class), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_alusrc(id_alusrc), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .alu_result(alu_result),
    .mem_fwd_en(mem_fwd_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal), .ex_operation(ex_operation),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_store_data(ex_store_data), .ex_rd(ex_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the ID port (rs data / imm / pc set separately when needed).
  task automatic instr(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                       input logic alusrc, input logic mrd, input logic rwr,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid     = 1'b1;
    id_class     = cls;
    id_funct3    = f3;
    id_funct7b5  = f7;
    id_alusrc    = alusrc;
    id_mem_read  = mrd;
    id_reg_write = rwr;
    id_uses_rs1  = 1'b1;
    id_uses_rs2  = ~alusrc;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_class = '0; id_funct3 = '0; id_funct7b5 = 1'b0;
    id_alusrc = 1'b0; id_mem_read = 1'b0; id_reg_write = 1'b0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_data = '0;
    id_rs2_data = '0; id_imm = '0; id_pc = '0; alu_result = '0; mem_fwd_en = 1'b0;
    mem_rd = '0; mem_data = '0; wb_fwd_en = 1'b0; wb_rd = '0; wb_data = '0;
    ex_stall = 1'b0; flush = 1'b0;

    // Reset held for two edges
    step(); step();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_op", 32'(ex_operation), 32'd0);
    check("rst_srca", ex_srca, 32'd0);
    check("rst_srcb", ex_srcb, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    check("rst_flags", {29'd0, ex_mem_read, ex_reg_write, ex_illegal}, 32'd0);
    reset = 1'b0;
    step();
    check("idle_valid", 32'(ex_valid), 32'd0);
    check("idle_ready", 32'(id_ready), 32'd1);

    // R-type SUB then SRL
    instr(3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    id_rs1_data = 32'd10; id_rs2_data = 32'd3;
    step();
    check("sub_op", 32'(ex_operation), 32'b0110);
    check("sub_srca", ex_srca, 32'd10);
    check("sub_srcb", ex_srcb, 32'd3);
    check("sub_valid", 32'(ex_valid), 32'd1);
    check("sub_rd", 32'(ex_rd), 32'd3);
    instr(3'b010, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4);
    step();
    check("srl_op", 32'(ex_operation), 32'b1111);
    check("srl_illegal", 32'(ex_illegal), 32'd0);

    // Forwarding priority: A = ADD rd5 into EX
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5);
    step();
    alu_result = 32'h55; mem_fwd_en = 1'b1; mem_rd = 5'd5; mem_data = 32'h77;
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd6);
    id_rs1_data = 32'h11;
    step();
    check("fwd_ex", ex_srca, 32'h55);
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd0);
    step();
    check("fwd_mem", ex_srca, 32'h77);
    mem_rd = 5'd0; wb_fwd_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h88;
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 5'd0);
    id_rs1_data = 32'h2A;
    step();
    check("fwd_x0", ex_srca, 32'h2A);
    wb_rd = 5'd9;
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0);
    id_rs2_data = 32'h3;
    step();
    check("fwd_wb_a", ex_srca, 32'h88);
    check("fwd_wb_b", ex_srcb, 32'h88);
    check("fwd_wb_store", ex_store_data, 32'h88);
    mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;

    // Load-use: load rd7 then consumer of rs2=7
    instr(3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd7);
    id_imm = 32'd4; id_rs1_data = 32'h1000;
    step();
    check("ld_op", 32'(ex_operation), 32'b0010);
    check("ld_srcb_imm", ex_srcb, 32'd4);
    instr(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd7, 5'd8);
    id_rs2_data = 32'h5;
    #1;
    check("lu_ready", 32'(id_ready), 32'd0);
    step();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_ready_bub", 32'(id_ready), 32'd1);
    mem_fwd_en = 1'b1; mem_rd = 5'd7; mem_data = 32'h99;
    step();
    check("lu_valid", 32'(ex_valid), 32'd1);
    check("lu_srcb", ex_srcb, 32'h99);
    mem_fwd_en = 1'b0;

    // Stall for three cycles with a different instruction waiting
    instr(3'b010, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9);
    id_rs2_data = 32'h1234;
    ex_stall = 1'b1;
    #1;
    check("stall_ready", 32'(id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_op", 32'(ex_operation), 32'b0010);
      check("stall_srcb", ex_srcb, 32'h99);
      check("stall_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(id_ready), 32'd1);
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // JAL, JAL with wrapping pc, LUI, branches
    instr(3'b101, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);
    id_pc = 32'h100;
    step();
    check("jal_srca", ex_srca, 32'h104);
    check("jal_op", 32'(ex_operation), 32'b0011);
    id_pc = 32'hFFFF_FFFC;
    step();
    check("jal_wrap", ex_srca, 32'h0);
    instr(3'b100, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2);
    id_imm = 32'h1234_5000;
    step();
    check("lui_srcb", ex_srcb, 32'h1234_5000);
    check("lui_op", 32'(ex_operation), 32'b1011);
    instr(3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    step();
    check("bltu_op", 32'(ex_operation), 32'b0000);
    check("bltu_illegal", 32'(ex_illegal), 32'd1);
    check("bltu_valid", 32'(ex_valid), 32'd1);
    instr(3'b001, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    step();
    check("bge_op", 32'(ex_operation), 32'b1010);
    check("bge_illegal", 32'(ex_illegal), 32'd0);
    instr(3'b011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd3);
    step();
    check("addi_f7_op", 32'(ex_operation), 32'b0010);
    instr(3'b011, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd3);
    step();
    check("srai_op", 32'(ex_operation), 32'b1110);
    instr(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    step();
    check("rsvd_illegal", 32'(ex_illegal), 32'd1);
    id_valid = 1'b0;
    step();
    check("end_idle", 32'(ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register that feeds the pipeline ALU. Each cycle it accepts one decoded instruction from ID. It translates the instruction class, funct3 and funct7[5] into the ALU's 4-bit `Operation` code, and selects forwarded operands. It also inserts a load-use bubble when required, then registers `SrcA`, `SrcB` and `Operation` for the combinational ALU in EX. It is the producer side of the ALU interface and closes the EX→ID forwarding loop using the ALU's own result.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `id_valid` in 1 / `id_ready` out 1: ID handshake; an instruction transfers when both are 1 at the edge
- `id_class`  in  3  000 LOAD/STORE, 001 BRANCH, 010 R, 011 I-ALU, 100 LUI, 101 JAL/JALR, 110 AUIPC, 111 reserved
- `id_funct3` in 3, `id_funct7b5` in 1: instruction fields
- `id_alusrc`  in  1  SrcB = immediate
- `id_mem_read`, `id_reg_write`  in  1  load / writes rd
- `id_uses_rs1`, `id_uses_rs2`  in  1  operand actually read
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc`  in  DATA_WIDTH
- `alu_result`  in  DATA_WIDTH  current ALU output (instruction in EX)
- `mem_fwd_en` in 1, `mem_rd` in REG_ADDR, `mem_data` in DATA_WIDTH: MEM-stage writeback
- `wb_fwd_en` in 1, `wb_rd` in REG_ADDR, `wb_data` in DATA_WIDTH: WB-stage writeback
- `ex_stall`  in  1  downstream hold
- `flush`  in  1  kill EX contents (branch/jump redirect)
- `ex_valid`, `ex_mem_read`, `ex_reg_write`, `ex_illegal`  out  1
- `ex_operation`  out  OPCODE_LENGTH  to ALU `Operation`
- `ex_srca`, `ex_srcb`, `ex_store_data`  out  DATA_WIDTH
- `ex_rd`  out  REG_ADDR

## Operation
- **Operation codes:** AND 0000, OR 0001, ADD 0010, PASS-A 0011, XOR 0101, SUB 0110, SLL 0111, EQ 1000, NE 1001, GE 1010, PASS-B 1011, LT 1100, SRA 1110, SRL 1111.
- **Class decode:**
  - LOAD/STORE and AUIPC → ADD.
  - LUI → 1011.
  - JAL/JALR → 0011.
  - Reserved → 0000, with `illegal` set.
- **BRANCH by funct3:** 000→1000, 001→1001, 100→1100, 101→1010. funct3 110/111 (unsigned branches) → 0000 with `illegal` set.
- **R and I by funct3:**
  - 000 → ADD. R-type with funct7b5=1 → SUB; I-type is always ADD.
  - 001 → SLL.
  - 010 → LT.
  - 100 → XOR.
  - 101 → SRA if funct7b5 = 1, else SRL.
  - 110 → OR.
  - 111 → AND.
  - 011 (SLTU) → 0000 with `illegal` set.
- Illegal instructions still issue, with `ex_illegal` = 1.
- **Operand forwarding** (per rs, for `fwd_rsN`), in priority order:
  1. EX: `ex_valid & ex_reg_write & !ex_mem_read & ex_rd==rsN` → `alu_result`.
  2. MEM: `mem_fwd_en & mem_rd==rsN` → `mem_data`.
  3. WB: `wb_fwd_en & wb_rd==rsN` → `wb_data`.
  4. Otherwise the register-file data.
  - rsN = 0 is never forwarded.
- **SrcA:** AUIPC → `id_pc`; JAL/JALR → `id_pc + 4` (wraps modulo 2^DATA_WIDTH); else `fwd_rs1`.
- **SrcB:** `id_alusrc` ? `id_imm` : `fwd_rs2`. `ex_store_data` = `fwd_rs2` always.
- **Hazard:** `hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- **State machine:**
  - RUN: the hazard with no stall and no flush → BUBBLE. The edge loads `ex_valid`=0 and does not accept ID.
  - BUBBLE: unconditionally → RUN next edge. The instruction now forwards the load data from MEM.
  - flush or reset forces RUN.
- **Handshake:** `id_ready = flush | (!ex_stall & !hazard)`, combinational.

## Timing
- All `ex_*` outputs are registered. Issue latency is one cycle: ID transfer at edge N → `ex_*` valid after edge N.
- Edge priority, highest first:
  1. reset: all `ex_*` = 0, state RUN.
  2. flush: `ex_valid` = 0 and the ID instruction is discarded, even when `ex_stall` = 1.
  3. `ex_stall`: every register holds.
  4. hazard: bubble, `ex_valid` = 0, other fields don't-care.
  5. transfer: load the decoded instruction.
  6. No transfer (`id_valid` = 0): `ex_valid` = 0.
- Fields are don't-care when `ex_valid` = 0.
- `ex_stall` combined with a hazard: hold, no bubble. The hazard re-evaluates when the stall releases.
- Reset asserted mid-bubble returns to RUN with everything cleared.
- `id_ready` with `reset` high: don't-care.

## Test plan
- Reset: hold `reset` 2 cycles → all `ex_*` = 0. After release with `id_valid` = 0, `ex_valid` stays 0 and `id_ready` = 1.
- R-type decode: class 010, funct3 000, f7b5 = 1, rs1 data 10, rs2 data 3 → next cycle `ex_operation` 0110, `ex_srca` 10, `ex_srcb` 3, `ex_valid` 1. Then funct3 101 with f7b5 = 0 → 1111.
- Forward priority: EX holds ADD rd = 5 with `alu_result` 0x55, `mem_rd` = 5 with `mem_data` 0x77, ID rs1 = 5 → `ex_srca` 0x55. Drop the EX match → 0x77. rs1 = 0 with every port matching → regfile value.
- Load-use: EX holds a load with rd = 7, ID uses rs2 = 7 → `id_ready` 0 and `ex_valid` 0 next cycle. The following cycle, with `mem_rd` 7 and `mem_data` 0x99, the instruction issues with `ex_srcb` 0x99.
- Stall/flush: `ex_stall` held 3 cycles → outputs frozen. `flush` together with `ex_stall` → `ex_valid` 0 after the next edge.
- Special classes:
  - JAL at pc 0x100 → `ex_srca` 0x104, `ex_operation` 0011.
  - LUI with imm 0x12345000 → `ex_srcb` 0x12345000, `ex_operation` 1011.
  - Branch funct3 110 → `ex_operation` 0000, `ex_illegal` 1.
